booth_sequencer: RTL
====================

BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 12, max cycles in RUN before abort; legal range 9..15.
REQ-002 Port: clock  input  1  sole clock, rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand pair offered.
REQ-005 Port: in_ready  output  1  operand pair accepted when in_valid & in_ready at rising edge.
REQ-006 Port: in_a  input  8  signed multiplicand (two's complement).
REQ-007 Port: in_b  input  8  signed multiplier (two's complement).
REQ-008 Port: out_valid  output  1  product available.
REQ-009 Port: out_ready  input  1  consumer takes product when out_valid & out_ready at rising edge.
REQ-010 Port: out_product  output  16  signed product.
REQ-011 Port: err  output  1  sticky timeout flag.
REQ-012 Port: ops_done  output  8  count of delivered products, wraps 255->0.
REQ-013 Port: mul_num1 / mul_num2  output  8 each  operands driven to the booths multiplier (num1, num2).
REQ-014 Port: mul_start  output  1  drives booths start.
REQ-015 Port: mul_result  input  16  booths result.
REQ-016 Port: mul_validity  input  1  booths validity; 1 = iterating, 0 = result final.

Function
REQ-017 FSM states: IDLE, LOAD, RUN, HOLD; all outputs registered except in_ready.
REQ-018 IDLE: in_ready=1; on accept, latch in_a->mul_num1, in_b->mul_num2; go to LOAD.
REQ-019 LOAD: exactly one cycle; mul_start=1; go to RUN; mul_start=0 in all other states.
REQ-020 mul_num1/mul_num2 stay stable from LOAD until the next accept.
REQ-021 RUN: wait counter cleared on entry, increments each RUN cycle.
REQ-022 RUN: on the first cycle with mul_validity=0, capture mul_result into out_product and go to HOLD.
REQ-023 mul_validity is ignored in LOAD. The multiplier keeps iterating after completion, and its validity re-asserts on count wrap. Capture therefore occurs only on the first RUN cycle with mul_validity=0.
REQ-024 Latency: accept at edge N -> mul_start high in cycle N+1 -> out_valid high from edge N+10 with a conforming multiplier (8 iterations).
REQ-025 RUN timeout: if the wait counter reaches TIMEOUT with mul_validity still 1:
- set err=1
- out_product is not updated
- return to IDLE without asserting out_valid.
REQ-026 HOLD: out_valid=1 and out_product held stable until handshake; out_product is unaffected by later mul_result changes.
REQ-027 HOLD handshake (out_ready=1) increments ops_done and clears out_valid at that edge.
REQ-028 in_ready = (state==IDLE) | (state==HOLD & out_ready).
REQ-029 Simultaneous handshake in HOLD: when out_ready and in_valid are both 1, deliver and accept in the same edge and go directly to LOAD (zero bubble).
REQ-030 HOLD with out_ready=1 and in_valid=0 goes to IDLE.
REQ-031 Arithmetic: product is the signed 16-bit value as produced by the multiplier. Operand -128 is passed through unmodified; its product correctness is the multiplier's responsibility.
REQ-032 err is sticky and cleared only by reset; operation continues normally after err.

Reset
REQ-033 Reset asserted asynchronously forces:
- state=IDLE, out_valid=0, out_product=0
- err=0, ops_done=0
- mul_num1=0, mul_num2=0, mul_start=0
- wait counter=0.
REQ-034 Reset mid-operation (LOAD/RUN/HOLD) discards the operation; no out_valid follows deassertion.
REQ-035 in_ready=1 in the first cycle after reset deassertion.

Structure
REQ-036 Shared package holds:
- FSM state enum
- operand width (8) and product width (16)
- TIMEOUT default constant.
REQ-037 No sub-module: booths is instantiated beside booth_sequencer by the integrating top level, not inside it.

Verification
REQ-038 in_a=3, in_b=5 accepted at edge 0 -> mul_start=1 for one cycle; out_valid rises at edge 10; out_product=0x000F.
REQ-039 in_a=0x07, in_b=0xFD (7 x -3) -> out_product=0xFFEB; with out_ready=1 held, ops_done 0->1.
REQ-040 out_ready=0 for 20 cycles after completion -> out_product stays at the captured value, out_valid stays 1, and in_ready stays 0.
REQ-041 Back-to-back: in HOLD with out_ready=1 and in_valid=1 (0xFF x 0xFF) -> same-edge accept; next product 0x0001 ten cycles later; ops_done=2.
REQ-042 Stub multiplier holds mul_validity=1 -> err=1 after TIMEOUT RUN cycles; out_valid never asserts; FSM in IDLE with in_ready=1.
REQ-043 Reset pulsed during RUN -> all outputs return to reset values immediately; no out_valid after deassertion.

Source files
------------

// File: rtl/booth_sequencer_pkg.sv
// Shared types and constants for the Booth multiplier sequencer.
package booth_sequencer_pkg;

    // Operand and product widths of the attached Booth multiplier.
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    // Default RUN-state budget; legal overrides are 9..15, so a 4-bit
    // wait counter always covers the full range.
    localparam int TIMEOUT_DEFAULT = 12;
    localparam int WAIT_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } seq_state_t;

endpackage

// File: rtl/booth_sequencer.sv
// Sequencer driving an external Booth multiplier: accepts an operand pair,
// pulses start, waits for the result with a timeout, then holds the product
// until the consumer takes it.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for an operand pair
//   LOAD  | one-cycle start pulse to the multiplier, validity ignored
//   RUN   | waiting for validity to drop; aborts with err after TIMEOUT
//   HOLD  | product presented until out_ready; can accept next pair
module booth_sequencer
    import booth_sequencer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_product,
    output logic              err,
    output logic [7:0]        ops_done,
    output logic [OP_W-1:0]   mul_num1,
    output logic [OP_W-1:0]   mul_num2,
    output logic              mul_start,
    input  logic [PROD_W-1:0] mul_result,
    input  logic              mul_validity
);

    // Value of the wait counter during the TIMEOUT-th RUN cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    seq_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              accept;

    // in_ready is the only combinational output so HOLD can hand over and
    // take a new pair on the same edge.
    assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    // Sequencer FSM with all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
            err         <= 1'b0;
            ops_done    <= '0;
            mul_num1    <= '0;
            mul_num2    <= '0;
            mul_start   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mul_num1  <= in_a;
                        mul_num2  <= in_b;
                        mul_start <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    mul_start <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= ST_RUN;
                end

                ST_RUN: begin
                    if (!mul_validity) begin
                        out_product <= mul_result;
                        out_valid   <= 1'b1;
                        state       <= ST_HOLD;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ops_done  <= ops_done + 8'd1;
                        if (in_valid) begin
                            mul_num1  <= in_a;
                            mul_num2  <= in_b;
                            mul_start <= 1'b1;
                            state     <= ST_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    mul_start <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
